// File: rtl/blit_sequencer.sv
// blit_sequencer: small command FIFO in front of the blitter plus a
// single-outstanding issue FSM (enable strobe, ready-low ack, ready-high done).
module blit_sequencer #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [11:0]            cmd_src,
  input  logic [3:0]             cmd_srcHeight,
  input  logic [6:0]             cmd_destX,
  input  logic [5:0]             cmd_destY,
  input  logic                   collision_clear,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done,
  output logic                   last_collision,
  output logic                   collision,
  output logic                   timeout_err,
  output logic [2:0]             blit_op,
  output logic [11:0]            blit_src,
  output logic [3:0]             blit_srcHeight,
  output logic [6:0]             blit_destX,
  output logic [5:0]             blit_destY,
  output logic                   blit_enable,
  input  logic                   blit_ready,
  input  logic                   blit_collision
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              LW      = AW + 1;
  localparam logic [LW-1:0]   FULL    = LW'(DEPTH);
  localparam logic [3:0]      ACK_MAX = 4'(ACK_TIMEOUT);

  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] src;
    logic [3:0]  h;
    logic [6:0]  x;
    logic [5:0]  y;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          cmd_in, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  state_t        state, state_nx;
  logic [3:0]    ack_cnt, ack_cnt_nx;
  logic          fin, fin_col, ack_to;

  assign cmd_in      = {cmd_op, cmd_src, cmd_srcHeight, cmd_destX, cmd_destY};
  assign head        = mem[rd_ptr];
  // Full is judged on the registered level only: a same-cycle pop never frees a slot early.
  assign cmd_ready   = (level != FULL);
  assign push        = cmd_valid && cmd_ready;
  assign blit_enable = (state == S_ISSUE);
  assign busy        = (level != '0) || (state != S_IDLE);

  // FIFO storage; contents need no reset, occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // State and ack-timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ack_cnt <= '0;
    end else begin
      state   <= state_nx;
      ack_cnt <= ack_cnt_nx;
    end
  end

  // Next state, pop request and completion events.
  always_comb begin
    state_nx   = state;
    ack_cnt_nx = ack_cnt;
    pop        = 1'b0;
    fin        = 1'b0;
    fin_col    = 1'b0;
    ack_to     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((level != '0) && blit_ready) begin
          pop      = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ack_cnt_nx = '0;
        state_nx   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!blit_ready) begin
          state_nx = S_WAIT_DONE;
        end else begin
          ack_cnt_nx = ack_cnt + 4'd1;
          if (ack_cnt_nx == ACK_MAX) begin
            ack_to   = 1'b1;
            fin      = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (blit_ready) begin
          fin      = 1'b1;
          fin_col  = blit_collision;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command fields to the blitter: loaded on pop, held until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY} <= '0;
    else if (pop)
      {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY} <= head;
  end

  // Completion status; a collision being recorded beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done           <= 1'b0;
      last_collision <= 1'b0;
      collision      <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      done <= fin;
      if (fin) last_collision <= fin_col;
      if (fin_col)              collision <= 1'b1;
      else if (collision_clear) collision <= 1'b0;
      if (ack_to) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_blit_sequencer.sv
// Bench for blit_sequencer: directed table, hand-written corner sequences and a
// randomized run against a counting/queue scoreboard, with a reactive blitter model.
module tb_blit_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [11:0] cmd_src;
  logic [3:0]  cmd_srcHeight;
  logic [6:0]  cmd_destX;
  logic [5:0]  cmd_destY;
  logic        collision_clear;
  logic [2:0]  level;
  logic        busy, done, last_collision, collision, timeout_err;
  logic [2:0]  blit_op;
  logic [11:0] blit_src;
  logic [3:0]  blit_srcHeight;
  logic [6:0]  blit_destX;
  logic [5:0]  blit_destY;
  logic        blit_enable, blit_ready, blit_collision;

  blit_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_srcHeight(cmd_srcHeight),
    .cmd_destX(cmd_destX), .cmd_destY(cmd_destY),
    .collision_clear(collision_clear), .level(level), .busy(busy), .done(done),
    .last_collision(last_collision), .collision(collision), .timeout_err(timeout_err),
    .blit_op(blit_op), .blit_src(blit_src), .blit_srcHeight(blit_srcHeight),
    .blit_destX(blit_destX), .blit_destY(blit_destY), .blit_enable(blit_enable),
    .blit_ready(blit_ready), .blit_collision(blit_collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] src;
    logic [3:0]  h;
    logic [6:0]  x;
    logic [5:0]  y;
  } cmd_t;

  typedef struct {
    cmd_t c;
    int   lat;       // blitter busy length; <=0 means it never acknowledges
    bit   col;
    bit   clr;       // pulse collision_clear on the completing cycle
    bit   exp_last;
    bit   exp_col;
  } vec_t;

  wire [31:0] blit_pk = {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY};

  function automatic logic [31:0] pk(input cmd_t c);
    return {c.op, c.src, c.h, c.x, c.y};
  endfunction

  function automatic cmd_t mkc(input logic [2:0] op, input logic [11:0] src,
                               input logic [3:0] h, input logic [6:0] x, input logic [5:0] y);
    cmd_t c;
    c.op = op; c.src = src; c.h = h; c.x = x; c.y = y;
    return c;
  endfunction

  function automatic vec_t mkv(input cmd_t c, input int lat, input bit col, input bit clr,
                               input bit el, input bit ec);
    vec_t v;
    v.c = c; v.lat = lat; v.col = col; v.clr = clr; v.exp_last = el; v.exp_col = ec;
    return v;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Blitter model: per issued command (counted since reset) it drops ready for
  // bm_ln[k] cycles, then raises it with bm_cl[k]; bm_ln[k]<=0 never acknowledges.
  logic bm_ready, bm_coll, bm_clear, man_ready, man_clear;
  int   bm_cnt, bm_idx;
  int   bm_ln [512];
  bit   bm_cl [512];
  bit   bm_cr [512];

  assign blit_ready      = bm_ready & man_ready;
  assign blit_collision  = bm_coll;
  assign collision_clear = bm_clear | man_clear;

  initial begin
    bm_ready = 1'b1; bm_coll = 1'b0; bm_clear = 1'b0; bm_cnt = 0; bm_idx = 0;
    forever begin
      @(negedge clk);
      bm_clear = 1'b0;
      if (!rst_n) begin
        bm_ready = 1'b1; bm_coll = 1'b0; bm_cnt = 0; bm_idx = 0;
      end else if (bm_cnt > 0) begin
        bm_cnt--;
        if (bm_cnt == 0) begin
          bm_ready = 1'b1;
          bm_coll  = bm_cl[bm_idx-1];
          bm_clear = bm_cr[bm_idx-1];
        end
      end else if (blit_enable) begin
        if (bm_ln[bm_idx] > 0) begin
          bm_ready = 1'b0; bm_coll = 1'b0; bm_cnt = bm_ln[bm_idx];
        end
        bm_idx++;
      end
    end
  end

  task automatic push(input cmd_t c);
    cmd_valid = 1'b1;
    cmd_op = c.op; cmd_src = c.src; cmd_srcHeight = c.h; cmd_destX = c.x; cmd_destY = c.y;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Tick until done (on_done=1) or blit_enable is seen; n = cycles taken (lim on expiry).
  task automatic wait_for(input bit on_done, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < lim && !(on_done ? done : blit_enable));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    cmd_t bb [5];
    cmd_t c, c1, c2;
    cmd_t fq [$];
    bit   lq [$];
    int   n, idx, nd, mism, acc, iss, dn;
    bit   busy_prev, e, exp_col, exp_to, prev_push, prev_clr, prev_en;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_srcHeight = '0;
    cmd_destX = '0; cmd_destY = '0; man_ready = 1'b1; man_clear = 1'b0;
    for (int i = 0; i < 512; i++) begin bm_ln[i] = 3; bm_cl[i] = 1'b0; bm_cr[i] = 1'b0; end

    tbl[0] = mkv(mkc(3'd1, 12'h200, 4'd5, 7'd10, 6'd3),  20, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[1] = mkv(mkc(3'd2, 12'h0ab, 4'd1, 7'd0, 6'd0),    2, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2] = mkv(mkc(3'd3, 12'hfff, 4'hf, 7'h7f, 6'h3f),  4, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mkv(mkc(3'd4, 12'h123, 4'd8, 7'h40, 6'h20),  6, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[4] = mkv(mkc(3'd7, 12'h800, 4'd0, 7'd1, 6'd1),    3, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enable", 32'(blit_enable), 0);
    chk("rst_fields", blit_pk, 0);
    chk("rst_status", 32'({done, last_collision, collision, timeout_err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single commands from the table, one at a time
    for (int r = 0; r < 5; r++) begin
      bm_ln[r] = tbl[r].lat; bm_cl[r] = tbl[r].col; bm_cr[r] = tbl[r].clr;
      push(tbl[r].c);
      chk("en_early", 32'(blit_enable), 0);
      @(negedge clk);
      chk("en_latency", 32'(blit_enable), 1);
      chk("issue_fields", blit_pk, pk(tbl[r].c));
      n = 0; mism = 0; busy_prev = 1'b0;
      while (n < 100) begin
        busy_prev = busy;
        @(negedge clk);
        n++;
        if (n == 1) chk("en_width", 32'(blit_enable), 0);
        if (blit_pk !== pk(tbl[r].c)) mism++;
        if (done) break;
      end
      chk("done_time", n, tbl[r].lat + 1);
      chk("busy_before_done", 32'(busy_prev), 1);
      chk("fields_held", mism, 0);
      chk("last_collision", 32'(last_collision), 32'(tbl[r].exp_last));
      chk("collision", 32'(collision), 32'(tbl[r].exp_col));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 0);
      chk("busy_after_done", 32'(busy), 0);
      chk("fields_retained", blit_pk, pk(tbl[r].c));
    end

    // back-to-back fill with the blitter not ready; fifth push must bounce
    for (int i = 0; i < 5; i++)
      bb[i] = mkc(3'(i + 1), 12'(16'h0310 + i * 16'h0111), 4'(i + 2), 7'(i * 9), 6'(i * 5 + 1));
    man_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(bb[i]);
    chk("b2b_level_full", 32'(level), 4);
    chk("b2b_ready_low", 32'(cmd_ready), 0);
    push(bb[4]);
    chk("b2b_fifth_ignored", 32'(level), 4);
    nd = 0;
    for (int t = 0; t < 3; t++) begin @(negedge clk); if (blit_enable) nd++; end
    chk("b2b_no_issue_unready", nd, 0);
    chk("b2b_level_hold", 32'(level), 4);
    man_ready = 1'b1;
    idx = 0; nd = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (t == 0) chk("b2b_release_issue", 32'(blit_enable), 1);
      if (blit_enable) begin
        if (idx < 4) begin
          chk("b2b_fields", blit_pk, pk(bb[idx]));
          chk("b2b_level", 32'(level), 32'(3 - idx));
        end
        idx++;
      end
      if (done) nd++;
    end
    chk("b2b_issued", idx, 4);
    chk("b2b_done_count", nd, 4);

    // ack timeout followed by a normal command
    c1 = mkc(3'd5, 12'h5a5, 4'd3, 7'd33, 6'd12);
    c2 = mkc(3'd6, 12'h3c3, 4'd9, 7'd66, 6'd44);
    bm_ln[9] = -1; bm_ln[10] = 3; bm_cl[10] = 1'b1;
    push(c1); push(c2);
    chk("to_issue", 32'(blit_enable), 1);
    chk("to_fields", blit_pk, pk(c1));
    chk("to_err_pre", 32'(timeout_err), 0);
    wait_for(1'b1, 40, n);
    chk("to_done_time", n, TO + 1);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_last", 32'(last_collision), 0);
    wait_for(1'b0, 10, n);
    chk("to_next_latency", n, 1);
    chk("to_next_fields", blit_pk, pk(c2));
    wait_for(1'b1, 20, n);
    chk("to_next_done_time", n, 4);
    chk("to_next_last", 32'(last_collision), 1);
    chk("to_err_sticky", 32'(timeout_err), 1);

    // async reset while a command is in WAIT_DONE with more queued
    bm_ln[11] = 30; bm_ln[12] = 30; bm_ln[13] = 30;
    push(bb[0]); push(bb[1]); push(bb[2]);
    repeat (5) @(negedge clk);
    chk("ar_pre_level", 32'(level), 2);
    chk("ar_pre_busy", 32'(busy), 1);
    chk("ar_pre_sticky", 32'({collision, timeout_err}), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_enable", 32'(blit_enable), 0);
    chk("ar_level", 32'(level), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_sticky", 32'({done, collision, timeout_err, last_collision}), 0);
    chk("ar_fields", blit_pk, 0);
    chk("ar_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 512; i++) begin
      bm_ln[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(2, 8));
      bm_cl[i] = ($urandom & 1) != 0;
      bm_cr[i] = 1'b0;
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the scoreboard
    acc = 0; iss = 0; dn = 0;
    exp_col = 1'b0; exp_to = 1'b0; prev_push = 1'b0; prev_clr = 1'b0; prev_en = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      if (prev_push) acc++;
      if (blit_enable) begin
        chk("rnd_en_width", 32'(prev_en), 0);
        chk("rnd_issue_pending", 32'(fq.size() != 0), 1);
        if (fq.size() != 0) begin
          c = fq.pop_front();
          chk("rnd_fields", blit_pk, pk(c));
        end
        lq.push_back(bm_ln[iss] > 0 ? bm_cl[iss] : 1'b0);
        iss++;
      end
      prev_en = blit_enable;
      if (done) begin
        chk("rnd_done_pending", 32'(lq.size() != 0), 1);
        e = (lq.size() != 0) ? lq.pop_front() : 1'b0;
        chk("rnd_last", 32'(last_collision), 32'(e));
        if (bm_ln[dn] <= 0) exp_to = 1'b1;
        dn++;
        if (e) exp_col = 1'b1;
        else if (prev_clr) exp_col = 1'b0;
      end else if (prev_clr) begin
        exp_col = 1'b0;
      end
      chk("rnd_level", 32'(level), acc - iss);
      chk("rnd_cmd_ready", 32'(cmd_ready), 32'((acc - iss) != DEPTH));
      chk("rnd_busy", 32'(busy), 32'((acc != iss) || (iss != dn)));
      chk("rnd_collision", 32'(collision), 32'(exp_col));
      chk("rnd_timeout_err", 32'(timeout_err), 32'(exp_to));
      if (t < 1300 && $urandom_range(0, 1) == 1) begin
        c = mkc(3'($urandom), 12'($urandom), 4'($urandom), 7'($urandom), 6'($urandom));
        cmd_valid = 1'b1;
        cmd_op = c.op; cmd_src = c.src; cmd_srcHeight = c.h; cmd_destX = c.x; cmd_destY = c.y;
        prev_push = (acc - iss) != DEPTH;
        if (prev_push) fq.push_back(c);
      end else begin
        cmd_valid = 1'b0;
        prev_push = 1'b0;
      end
      man_clear = ($urandom_range(0, 15) == 0);
      prev_clr  = man_clear;
    end
    cmd_valid = 1'b0; man_clear = 1'b0;
    chk("rnd_all_issued", iss, acc);
    chk("rnd_all_done", dn, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
